// File: rtl/ysyx_22041752_div.sv
// ysyx_22041752_div: multi-cycle radix-2 restoring divider for RV64M
// DIV/DIVU/REM/REMU and their W forms. One quotient bit per cycle; division
// by zero and signed overflow short-circuit straight to DONE.
module ysyx_22041752_div #(
  parameter int WIDTH  = 64,
  parameter int WWIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             div_valid,
  input  logic             div_signed,
  input  logic             div_w,
  input  logic             div_rem,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] result,
  output logic             out_valid
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sign-extend a W-sized value to full width.
  function automatic logic [WIDTH-1:0] sext_w(input logic [WWIDTH-1:0] v);
    return {{(WIDTH-WWIDTH){v[WWIDTH-1]}}, v};
  endfunction

  // Zero-extend a W-sized value to full width.
  function automatic logic [WIDTH-1:0] zext_w(input logic [WWIDTH-1:0] v);
    return {{(WIDTH-WWIDTH){1'b0}}, v};
  endfunction

  // Two's-complement negate when requested; the most-negative value maps to
  // itself, which is exactly its unsigned magnitude.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  localparam logic signed [WIDTH+1:0] ZERO_D = '0;

  state_t           state;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_mag_q;
  logic [CW-1:0]    cnt_q;
  logic             w_q;
  logic             rem_sel_q;
  logic             qsign_q;
  logic             rsign_q;

  // Accept-side operand decode
  logic [WIDTH-1:0] dvd_ext;
  logic [WIDTH-1:0] dvs_ext;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] min_neg;
  logic             dvs_zero;
  logic             ovf;
  logic [WIDTH-1:0] quo_init;

  // Iteration datapath
  logic [WIDTH:0]          rem_sh;
  logic signed [WIDTH+1:0] diff;
  logic                    take;
  logic [WIDTH-1:0]        rem_nxt;
  logic [WIDTH-1:0]        quo_nxt;
  logic [CW-1:0]           cnt_nxt;
  logic [CW-1:0]           n_lim;

  // Result formatting
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic [WIDTH-1:0] sel_fin;
  logic [WIDTH-1:0] res_fin;

  // Operand extension, magnitudes and special-case detection for the accept cycle
  always_comb begin
    dvd_ext  = div_w ? (div_signed ? sext_w(dividend[WWIDTH-1:0]) : zext_w(dividend[WWIDTH-1:0]))
                     : dividend;
    dvs_ext  = div_w ? (div_signed ? sext_w(divisor[WWIDTH-1:0]) : zext_w(divisor[WWIDTH-1:0]))
                     : divisor;
    dvd_neg  = div_signed & dvd_ext[WIDTH-1];
    dvs_neg  = div_signed & dvs_ext[WIDTH-1];
    dvd_mag  = cond_neg(dvd_ext, dvd_neg);
    dvs_mag  = cond_neg(dvs_ext, dvs_neg);
    min_neg  = div_w ? {{(WIDTH-WWIDTH+1){1'b1}}, {(WWIDTH-1){1'b0}}}
                     : {1'b1, {(WIDTH-1){1'b0}}};
    dvs_zero = (dvs_ext == '0);
    ovf      = div_signed & (dvd_ext == min_neg) & (dvs_ext == '1);
    // W operands sit in the upper half so the same full-width shift feeds
    // dividend bit 31 into the remainder first and leaves a clean upper half.
    quo_init = div_w ? (dvd_mag << WWIDTH) : dvd_mag;
  end

  // One restoring step: shift, trial subtract, keep the difference if non-negative
  always_comb begin
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    diff    = $signed({1'b0, rem_sh} - {2'b00, dvs_mag_q});
    take    = (diff >= ZERO_D);
    rem_nxt = take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], take};
    cnt_nxt = cnt_q + CW'(1);
    n_lim   = w_q ? CW'(WWIDTH) : CW'(WIDTH);
  end

  // Sign fix-up, quotient/remainder select and W sign-extension
  always_comb begin
    q_fin   = cond_neg(quo_q, qsign_q);
    r_fin   = cond_neg(rem_q, rsign_q);
    sel_fin = rem_sel_q ? r_fin : q_fin;
    res_fin = w_q ? sext_w(sel_fin[WWIDTH-1:0]) : sel_fin;
  end

  // Control FSM with registered result and one-cycle out_valid
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      result    <= '0;
      out_valid <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_mag_q <= '0;
      cnt_q     <= '0;
      w_q       <= 1'b0;
      rem_sel_q <= 1'b0;
      qsign_q   <= 1'b0;
      rsign_q   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (div_valid) begin
              w_q       <= div_w;
              rem_sel_q <= div_rem;
              dvs_mag_q <= dvs_mag;
              cnt_q     <= '0;
              if (dvs_zero) begin
                // Quotient all ones, remainder = dividend; DONE formats them.
                quo_q   <= '1;
                rem_q   <= dividend;
                qsign_q <= 1'b0;
                rsign_q <= 1'b0;
                state   <= DONE;
              end else if (ovf) begin
                // Quotient = dividend, remainder = 0.
                quo_q   <= dividend;
                rem_q   <= '0;
                qsign_q <= 1'b0;
                rsign_q <= 1'b0;
                state   <= DONE;
              end else begin
                quo_q   <= quo_init;
                rem_q   <= '0;
                qsign_q <= dvd_neg ^ dvs_neg;
                rsign_q <= dvd_neg;
                state   <= CALC;
              end
            end
          end
          CALC: begin
            if (!div_valid) begin
              state <= IDLE;
            end else begin
              rem_q <= rem_nxt;
              quo_q <= quo_nxt;
              cnt_q <= cnt_nxt;
              if (cnt_nxt == n_lim) state <= DONE;
            end
          end
          DONE: begin
            result    <= res_fin;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041752_div.sv
// Self-checking bench for ysyx_22041752_div: directed RV64M corner cases plus
// randomized operations checked against a plain-arithmetic reference model.
module tb_ysyx_22041752_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        div_valid;
  logic        div_signed;
  logic        div_w;
  logic        div_rem;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic [63:0] result;
  logic        out_valid;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_22041752_div #(.WIDTH(64), .WWIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .div_valid (div_valid),
    .div_signed(div_signed),
    .div_w     (div_w),
    .div_rem   (div_rem),
    .dividend  (dividend),
    .divisor   (divisor),
    .result    (result),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension division semantics from ISA rules
  function automatic logic [63:0] model(input logic s, input logic w, input logic r,
                                        input logic [63:0] a, input logic [63:0] b,
                                        output int lat);
    logic [31:0] ua, ub, q32, m32, sel32;
    int          sa, sb;
    longint      la, lb;
    logic [63:0] q64, m64;
    if (w) begin
      ua = a[31:0]; ub = b[31:0]; sa = ua; sb = ub; lat = 33;
      if (ub == 32'd0) begin
        q32 = 32'hFFFF_FFFF; m32 = ua; lat = 1;
      end else if (s && ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) begin
        q32 = ua; m32 = 32'd0; lat = 1;
      end else if (s) begin
        q32 = sa / sb; m32 = sa % sb;
      end else begin
        q32 = ua / ub; m32 = ua % ub;
      end
      sel32 = r ? m32 : q32;
      return {{32{sel32[31]}}, sel32};
    end else begin
      la = a; lb = b; lat = 65;
      if (b == 64'd0) begin
        q64 = '1; m64 = a; lat = 1;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q64 = a; m64 = 64'd0; lat = 1;
      end else if (s) begin
        q64 = la / lb; m64 = la % lb;
      end else begin
        q64 = a / b; m64 = a % b;
      end
      return r ? m64 : q64;
    end
  endfunction

  // Issue one divide and check latency, result and the single-cycle valid
  task automatic do_div(input string tag, input logic s, input logic w, input logic r,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_lat);
    int k;
    logic [63:0] got;
    @(negedge clk);
    div_valid = 1'b1; div_signed = s; div_w = w; div_rem = r;
    dividend = a; divisor = b;
    @(posedge clk);
    #1;
    dividend = {$urandom, $urandom};
    divisor  = {$urandom, $urandom};
    k = 0;
    got = '0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        k = i;
        got = result;
        break;
      end
    end
    div_valid = 1'b0;
    chk({tag, "_lat"}, 64'(k), 64'(exp_lat));
    chk({tag, "_res"}, got, exp_res);
    @(posedge clk);
    #1;
    chk({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_hold"}, result, got);
  endtask

  // Count out_valid pulses over a window of cycles
  task automatic count_valid(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) cnt++;
    end
  endtask

  initial begin
    int          lat, cnt;
    logic [63:0] a, b, e, held;
    logic        s, w, r;

    reset = 1'b0; flush = 1'b0; div_valid = 1'b0;
    div_signed = 1'b0; div_w = 1'b0; div_rem = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed cases
    do_div("divu_100_7", 0, 0, 0, 64'd100, 64'd7, 64'd14, 65);
    do_div("remu_100_7", 0, 0, 1, 64'd100, 64'd7, 64'd2, 65);
    do_div("div_m7_2", 1, 0, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    do_div("rem_m7_2", 1, 0, 1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    do_div("rem_7_m2", 1, 0, 1, 64'd7, -64'sd2, 64'd1, 65);
    do_div("div_by0", 1, 0, 0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    do_div("remuw_by0", 0, 1, 1, 64'h0000_0000_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1);
    do_div("div_ovf", 1, 0, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    do_div("rem_ovf", 1, 0, 1, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
    do_div("divw_ovf", 1, 1, 0, 64'h1357_9BDF_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1);
    do_div("divuw_ff_1", 0, 1, 0, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    do_div("divw_garb", 1, 1, 0, 64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_5678_0000_0002,
           64'hFFFF_FFFF_FFFF_FFFD, 33);
    do_div("remw_garb", 1, 1, 1, 64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_5678_0000_0002,
           64'hFFFF_FFFF_FFFF_FFFF, 33);

    // Flush at T+20 of a 64-bit divide
    held = result;
    @(negedge clk);
    div_valid = 1'b1; div_signed = 0; div_w = 0; div_rem = 0;
    dividend = 64'd1000; divisor = 64'd3;
    @(posedge clk);
    repeat (19) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; div_valid = 1'b0;
    count_valid(80, cnt);
    chk("flush_calc_novld", 64'(cnt), 64'd0);
    chk("flush_calc_hold", result, held);
    do_div("divu_9_3", 0, 0, 0, 64'd9, 64'd3, 64'd3, 65);

    // Flush landing on the DONE cycle of a divide-by-zero
    held = result;
    @(negedge clk);
    div_valid = 1'b1; div_signed = 0; div_w = 0; div_rem = 0;
    dividend = 64'h55; divisor = 64'd0;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; div_valid = 1'b0;
    count_valid(5, cnt);
    chk("flush_done_novld", 64'(cnt), 64'd0);
    chk("flush_done_hold", result, held);

    // Dropping div_valid mid-CALC abandons the operation
    @(negedge clk);
    div_valid = 1'b1; dividend = 64'd77; divisor = 64'd5;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    div_valid = 1'b0;
    count_valid(80, cnt);
    chk("abort_novld", 64'(cnt), 64'd0);
    chk("abort_hold", result, held);

    // Reset in the middle of CALC
    @(negedge clk);
    div_valid = 1'b1; div_signed = 0; div_w = 0; div_rem = 0;
    dividend = 64'd500; divisor = 64'd7;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_result", result, 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    div_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    count_valid(70, cnt);
    chk("midrst_novld", 64'(cnt), 64'd0);
    do_div("post_rst", 1, 0, 1, 64'd500, 64'd7, 64'd3, 65);

    // Randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      s = 1'($urandom); w = 1'($urandom); r = 1'($urandom);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ;
        1: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 50)); end
        2: b = w ? {$urandom, 32'd0} : 64'd0;
        3: begin
             if (w) begin a[31:0] = 32'h8000_0000; b[31:0] = 32'hFFFF_FFFF; end
             else begin a = 64'h8000_0000_0000_0000; b = '1; end
           end
        4: b = ($urandom_range(0, 1) != 0) ? '1 : 64'($urandom_range(1, 15));
        default: b = {b[63:1], 1'b1} | 64'h8000_0000_8000_0000;
      endcase
      e = model(s, w, r, a, b, lat);
      do_div($sformatf("rnd%0d", n), s, w, r, a, b, e, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
